costas_loop_filter: RTL and testbench

// - PI loop filter of the Costas carrier loop, directly downstream of the /30 tick generator (clock600 strobe + unlock window).
// - Integrates per-cycle phase-error samples during each unlock window, dumps on the tick, and emits a saturated NCO frequency word.
// - Sits between the phase detector (err_*) and the NCO (freq_word/out_valid).

---
 rtl/costas_loop_filter_if.sv | 24 ++
 rtl/costas_loop_filter.sv | 163 ++++++++++++++++
 tb/tb_costas_loop_filter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/costas_loop_filter_if.sv
// Phase-detector to NCO bundle for the Costas PI loop filter: window/tick controls in, frequency word out.
interface costas_loop_filter_if #(
    parameter int ERR_W = 12,
    parameter int FW_W  = 24
);
    logic                    tick;
    logic                    unlock;
    logic                    err_valid;
    logic signed [ERR_W-1:0] err_data;
    logic [FW_W-1:0]         freq_word;
    logic                    out_valid;
    logic                    locked;
    logic [7:0]              drop_cnt;

    modport master (
        output tick, unlock, err_valid, err_data,
        input  freq_word, out_valid, locked, drop_cnt
    );

    modport slave (
        input  tick, unlock, err_valid, err_data,
        output freq_word, out_valid, locked, drop_cnt
    );
endinterface

// File: rtl/costas_loop_filter.sv
// Costas PI loop filter: integrate phase error per unlock window, dump on tick, saturated NCO word (lock FSM: COSTAS_LOCK_DET_EN).
// Latency: tick -> out_valid 2 cycles, fully pipelined; empty windows produce no output.
// Backpressure: none; samples outside the window or beyond a full window are dropped and counted.
module costas_loop_filter #(
    parameter int              ERR_W     = 12,
    parameter int              CNT_W     = 5,
    parameter int              FW_W      = 24,
    parameter logic [FW_W-1:0] CENTER    = 24'h200000,
    parameter int              KP_SH_ACQ = 4,
    parameter int              KI_SH_ACQ = 8,
    parameter int              KP_SH_TRK = 6,
    parameter int              KI_SH_TRK = 11,
    parameter int              LOCK_THR  = 64,
    parameter int              LOCK_N    = 16
) (
    input  logic clock,
    input  logic resetn,
    costas_loop_filter_if.slave bus
);
    localparam int SUM_W = ERR_W + CNT_W;
    localparam int EXT_W = ((SUM_W > FW_W) ? SUM_W : FW_W) + 2;
    localparam logic [CNT_W-1:0]        N_MAX      = '1;
    localparam logic signed [EXT_W-1:0] INT_MAX    = EXT_W'((64'sd1 <<< (FW_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] INT_MIN    = EXT_W'(-(64'sd1 <<< (FW_W - 1)));
    localparam logic signed [EXT_W-1:0] FW_MAX     = EXT_W'((64'sd1 <<< FW_W) - 64'sd1);
    localparam logic signed [EXT_W-1:0] CENTER_EXT = {{(EXT_W - FW_W){1'b0}}, CENTER};

    if (LOCK_N < 1 || LOCK_THR < 0 || KP_SH_ACQ < 0 || KI_SH_ACQ < 0 ||
        KP_SH_TRK < 0 || KI_SH_TRK < 0) begin : g_bad_param
        $error("costas_loop_filter: gain shifts and lock parameters must be non-negative, LOCK_N >= 1");
    end

    logic signed [SUM_W-1:0] win_sum, dump_sum, err_ext;
    logic [CNT_W-1:0]        win_n;
    logic                    dump_vld;
    logic                    accept, reject;
    logic [7:0]              drop_cnt;
    logic signed [FW_W-1:0]  integ, integ_nxt;
    logic [FW_W-1:0]         freq_word, freq_nxt;
    logic                    out_valid;
    logic [5:0]              kp_sh, ki_sh;
    logic signed [EXT_W-1:0] sum_ext, p_ext, i_ext, integ_ext, integ_sum, integ_nxt_ext, freq_sum;

    // The tick cycle belongs to no window, so a sample arriving with it is rejected.
    assign accept  = bus.err_valid & bus.unlock & ~bus.tick & (win_n != N_MAX);
    assign reject  = bus.err_valid & ~accept;
    assign err_ext = {{CNT_W{bus.err_data[ERR_W-1]}}, bus.err_data};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            win_sum  <= '0;
            win_n    <= '0;
            dump_sum <= '0;
            dump_vld <= 1'b0;
            drop_cnt <= '0;
        end else begin
            dump_vld <= bus.tick && (win_n != '0);
            if (bus.tick) begin
                dump_sum <= win_sum;
                win_sum  <= '0;
                win_n    <= '0;
            end else if (accept) begin
                win_sum <= win_sum + err_ext;
                win_n   <= win_n + CNT_W'(1);
            end
            if (reject && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef COSTAS_LOCK_DET_EN
    typedef enum logic {ACQUIRE, TRACK} state_t;
    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic signed [EXT_W-1:0] THR = EXT_W'(LOCK_THR);

    state_t                  state, state_nxt;
    logic [RUN_W-1:0]        run, run_nxt;
    logic signed [EXT_W-1:0] sum_abs;
    logic                    qual;

    assign sum_abs = sum_ext[EXT_W-1] ? -sum_ext : sum_ext;
    assign qual    = (state == ACQUIRE) ? (sum_abs <= THR) : (sum_abs > THR);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ACQUIRE;
            run   <= '0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        if (dump_vld) begin
            if (!qual) begin
                run_nxt = '0;
            end else if (run == RUN_W'(LOCK_N - 1)) begin
                state_nxt = (state == ACQUIRE) ? TRACK : ACQUIRE;
                run_nxt   = '0;
            end else begin
                run_nxt = run + RUN_W'(1);
            end
        end
    end

    // Gains follow the state register, so a switch takes effect from the next dump.
    assign kp_sh      = (state == TRACK) ? 6'(KP_SH_TRK) : 6'(KP_SH_ACQ);
    assign ki_sh      = (state == TRACK) ? 6'(KI_SH_TRK) : 6'(KI_SH_ACQ);
    assign bus.locked = (state == TRACK);
`else
    assign kp_sh      = 6'(KP_SH_ACQ);
    assign ki_sh      = 6'(KI_SH_ACQ);
    assign bus.locked = 1'b0;
`endif

    assign sum_ext       = {{(EXT_W - SUM_W){dump_sum[SUM_W-1]}}, dump_sum};
    assign p_ext         = sum_ext >>> kp_sh;
    assign i_ext         = sum_ext >>> ki_sh;
    assign integ_ext     = {{(EXT_W - FW_W){integ[FW_W-1]}}, integ};
    assign integ_sum     = integ_ext + i_ext;
    assign integ_nxt_ext = {{(EXT_W - FW_W){integ_nxt[FW_W-1]}}, integ_nxt};
    assign freq_sum      = CENTER_EXT + p_ext + integ_nxt_ext;

    always_comb begin
        integ_nxt = integ_sum[FW_W-1:0];
        if (integ_sum > INT_MAX) begin
            integ_nxt = INT_MAX[FW_W-1:0];
        end else if (integ_sum < INT_MIN) begin
            integ_nxt = INT_MIN[FW_W-1:0];
        end
    end

    always_comb begin
        freq_nxt = freq_sum[FW_W-1:0];
        if (freq_sum[EXT_W-1]) begin
            freq_nxt = '0;
        end else if (freq_sum > FW_MAX) begin
            freq_nxt = '1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            integ     <= '0;
            freq_word <= CENTER;
            out_valid <= 1'b0;
        end else begin
            out_valid <= dump_vld;
            if (dump_vld) begin
                integ     <= integ_nxt;
                freq_word <= freq_nxt;
            end
        end
    end

    assign bus.freq_word = freq_word;
    assign bus.out_valid = out_valid;
    assign bus.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_costas_loop_filter.sv
// Scoreboarded bench: a 24-bit instance plus a 12-bit instance sharing stimulus, so saturation and clamping are reachable.
module tb_costas_loop_filter;
`ifdef COSTAS_LOCK_DET_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int     FWW [2] = '{24, 12};
    localparam longint CEN [2] = '{64'h200000, 64'h800};

    typedef struct {
        longint fw;
        bit     lk;
    } exp_t;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    costas_loop_filter_if #(.ERR_W(12), .FW_W(24)) bus0 ();
    costas_loop_filter_if #(.ERR_W(12), .FW_W(12)) bus1 ();

    assign bus1.tick      = bus0.tick;
    assign bus1.unlock    = bus0.unlock;
    assign bus1.err_valid = bus0.err_valid;
    assign bus1.err_data  = bus0.err_data;

    costas_loop_filter u_dut (.clock(clock), .resetn(resetn), .bus(bus0));
    costas_loop_filter #(.FW_W(12), .CENTER(12'h800)) u_sat (.clock(clock), .resetn(resetn), .bus(bus1));

    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   q0 [$];
    exp_t   q1 [$];
    longint m_integ [2];
    longint m_last  [2];
    longint m_sum;
    int     m_n, m_drop, m_state, m_run;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Floor division by 2^k, i.e. an arithmetic right shift stated as arithmetic.
    function automatic longint fshr(input longint x, input int k);
        longint d;
        d = longint'(1) << k;
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_integ[i] = 0;
            m_last[i]  = CEN[i];
        end
        m_sum = 0; m_n = 0; m_drop = 0; m_state = 0; m_run = 0;
    endtask

    task automatic model_dump();
        int kp, ki;
        longint p, inc, f, hi, lo, a;
        bit qual;
        exp_t e;
        if (m_n == 0) return;
        kp  = (m_state == 1) ? 6 : 4;
        ki  = (m_state == 1) ? 11 : 8;
        p   = fshr(m_sum, kp);
        inc = fshr(m_sum, ki);
        if (LOCK_EN) begin
            a    = (m_sum < 0) ? -m_sum : m_sum;
            qual = (m_state == 0) ? (a <= 64) : (a > 64);
            if (qual) begin
                m_run++;
                if (m_run == 16) begin
                    m_state = 1 - m_state;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            hi = (longint'(1) << (FWW[i] - 1)) - 1;
            lo = -hi - 1;
            m_integ[i] = m_integ[i] + inc;
            if (m_integ[i] > hi) m_integ[i] = hi;
            if (m_integ[i] < lo) m_integ[i] = lo;
            f = CEN[i] + p + m_integ[i];
            if (f < 0) f = 0;
            if (f > (longint'(1) << FWW[i]) - 1) f = (longint'(1) << FWW[i]) - 1;
            m_last[i] = f;
            e.fw = f;
            e.lk = (m_state == 1);
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic step(input bit tk, input bit ul, input bit vld, input int d);
        bus0.tick      = tk;
        bus0.unlock    = ul;
        bus0.err_valid = vld;
        bus0.err_data  = 12'(d);
        if (resetn) begin
            if (vld) begin
                if (ul && !tk && m_n < 31) begin
                    m_sum = m_sum + d;
                    m_n++;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (tk) begin
                model_dump();
                m_sum = 0;
                m_n   = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic window(input int ns, input int val);
        repeat (ns) step(1'b0, 1'b1, 1'b1, val);
        step(1'b1, 1'b1, 1'b0, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_freq0"}, bus0.freq_word, m_last[0]);
        check({tag, "_freq1"}, bus1.freq_word, m_last[1]);
        check({tag, "_drop"}, bus0.drop_cnt, m_drop);
        check({tag, "_locked"}, bus0.locked, (m_state == 1) ? 1 : 0);
    endtask

    exp_t e0, e1;
    always @(negedge clock) begin
        if (bus0.out_valid === 1'b1) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL out_valid0_unexpected: got out_valid=1, expected no output");
            end else begin
                e0 = q0.pop_front();
                check("freq_word0", bus0.freq_word, e0.fw);
                check("locked0", bus0.locked, e0.lk);
            end
        end
        if (bus1.out_valid === 1'b1) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL out_valid1_unexpected: got out_valid=1, expected no output");
            end else begin
                e1 = q1.pop_front();
                check("freq_word1", bus1.freq_word, e1.fw);
            end
        end
    end

    initial begin
        int len;
        resetn         = 1'b0;
        bus0.tick      = 1'b0;
        bus0.unlock    = 1'b0;
        bus0.err_valid = 1'b0;
        bus0.err_data  = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_freq0", bus0.freq_word, 64'h200000);
        check("rst_freq1", bus1.freq_word, 64'h800);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_locked", bus0.locked, 0);
        check("rst_drop", bus0.drop_cnt, 0);
        resetn = 1'b1;

        // Ten ticks with no samples at all.
        repeat (10) begin
            idle(29);
            step(1'b1, 1'b1, 1'b0, 0);
        end
        idle(3);
        check_idle("empty");

        // Out-of-window samples, then one on the tick cycle.
        repeat (5) step(1'b0, 1'b0, 1'b1, 100);
        step(1'b1, 1'b1, 1'b1, 50);
        idle(4);
        check("drop_six", bus0.drop_cnt, 6);
        check_idle("reject");

        window(27, 16);
        idle(4);
        check("basic_freq", bus0.freq_word, 64'h20001C);

        // Overlapping pipelines: dumps two cycles apart.
        step(1'b0, 1'b1, 1'b1, 5);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, -7);
        step(1'b1, 1'b1, 1'b0, 0);
        idle(4);
        check_idle("overlap");

        // Randomised windows, lengths beyond 31 exercise the full-window drop.
        for (int w = 0; w < 40; w++) begin
            len = $urandom_range(0, 36);
            for (int c = 0; c < len; c++) begin
                step(1'b0, ($urandom % 8) != 0, ($urandom % 4) != 0, int'($urandom_range(0, 4095)) - 2048);
            end
            step(1'b1, $urandom % 2, $urandom % 2, int'($urandom_range(0, 4095)) - 2048);
        end
        idle(4);
        check_idle("random");

        // Lock acquisition then loss, from a clean start.
        resetn = 1'b0;
        idle(2);
        model_reset();
        resetn = 1'b1;
        repeat (16) window(27, 1);
        idle(3);
        check("lock_acquired", bus0.locked, LOCK_EN ? 1 : 0);
        repeat (16) window(27, 16);
        idle(3);
        check("lock_lost", bus0.locked, 0);
        check_idle("lock");

        // Drive the 12-bit integrator into both rails, then nudge it off.
        repeat (15) window(31, 2047);
        window(27, -16);
        repeat (20) window(31, -2048);
        window(27, 16);
        idle(4);
        check_idle("saturate");

        repeat (260) step(1'b0, 1'b0, 1'b1, 3);
        check("drop_saturated", bus0.drop_cnt, 255);

        // Reset lands in the cycle after a tick: that dump must vanish.
        idle(4);
        repeat (27) step(1'b0, 1'b1, 1'b1, 16);
        bus0.tick      = 1'b1;
        bus0.err_valid = 1'b0;
        @(posedge clock);
        #1;
        bus0.tick = 1'b0;
        resetn    = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_out_valid", bus0.out_valid, 0);
        resetn = 1'b1;
        model_reset();
        idle(4);
        check("midrst_freq", bus0.freq_word, 64'h200000);
        check("midrst_drop", bus0.drop_cnt, 0);
        window(27, 16);
        idle(4);
        check("midrst_integ_zero", bus0.freq_word, 64'h20001C);

        idle(6);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
